bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Sequencer and arbiter for the shared OR-combined datapath bus. It grants bus-drive rights to one of N requesting sources at a time, using round-robin priority with a bounded hold time and an optional lock. It inserts one idle turnaround cycle between owners so the bus returns to all-zero. It also monitors source activity and flags any source that drives the bus without a grant, because overlapping drivers corrupt an OR bus silently.

## Interface
- p_num_masters, 4: number of bus sources, range 2..8.
- p_max_hold, 4: maximum cycles an unlocked owner keeps the bus while others wait, range 1..15.
- i_w_clk  input  1  clock, rising edge.
- i_w_rst_n  input  1  asynchronous reset, active-low.
- i_w_req  input  p_num_masters  per-source bus request, level.
- i_w_lock  input  p_num_masters  per-source lock; when the current owner's bit is set, the hold limit is ignored.
- i_w_src_active  input  p_num_masters  per-source indication that the source is driving a nonzero value on the bus.
- i_w_clr_err  input  1  clears o_r_conflict.
- o_r_grant  output  p_num_masters  one-hot drive enable to the sources; all zero when no owner.
- o_r_owner  output  clog2(p_num_masters)  index of the current owner; 0 when no owner.
- o_r_busy  output  1  high while in GRANT.
- o_r_preempt  output  1  one-cycle pulse on a forced release.
- o_r_conflict  output  1  sticky error flag.

## Operation
- States:
  - IDLE: no owner.
  - GRANT: one owner.
  - RELEASE: one turnaround cycle, grant all zero.
- Arbitration runs in IDLE and RELEASE when i_w_req != 0.
  - The winner is the first requesting index searched cyclically from rr_ptr.
  - Next state is GRANT. o_r_grant, o_r_owner and o_r_busy are registered with it.
  - The hold counter loads 1 and rr_ptr is set to (winner+1) mod N.
- IDLE with no request stays in IDLE. RELEASE with no request goes to IDLE.
- GRANT transitions are evaluated in this order:
  1. If i_w_req[owner]=0, go to RELEASE. This is a normal release with no preempt.
  2. Else if i_w_lock[owner]=1, stay in GRANT.
  3. Else if hold_cnt >= p_max_hold and any other i_w_req bit is set, go to RELEASE and pulse o_r_preempt in the RELEASE cycle.
  4. Otherwise stay in GRANT. hold_cnt increments and saturates at p_max_hold.
- The lock only prevents preemption. Dropping the request still releases the bus.
- Conflict detection:
  - A source j is in conflict when i_w_src_active[j]=1 and either the state is not GRANT or j != owner.
  - On any conflict, o_r_conflict is set at the next edge. It stays set until i_w_clr_err=1. If set and clear occur in the same cycle, set wins.
- hold_cnt width is clog2(p_max_hold+1). rr_ptr wraps from N-1 to 0.

## Timing
- Reset: state=IDLE, rr_ptr=0, hold_cnt=0, and all outputs are 0. Reset takes effect immediately, mid-grant included. Grant drops without a RELEASE cycle.
- Request-to-grant latency is one cycle. A request sampled at edge k makes the grant visible after edge k.
- A release decision at edge k gives grant=0 for exactly one cycle. The next owner, if any, is granted at edge k+1.
- Minimum tenure is 1 cycle. Minimum gap between owners is 1 cycle.
- An unlocked owner under contention holds the bus for exactly p_max_hold cycles.
- o_r_preempt is high for exactly one cycle, coincident with RELEASE.
- A request that arrives during RELEASE is eligible at that same edge.

## Test plan
All scenarios use N=4 and p_max_hold=4.
- Reset, then hold i_w_rst_n=0 for 3 cycles -> grant=0000, owner=0, busy=0, preempt=0, conflict=0.
- i_w_req=0100 from cycle 0 to 5, then 0000 -> grant=0100 and owner=2 in cycles 1..6; grant=0000 in cycle 7 (RELEASE); IDLE in cycle 8.
- i_w_req=1111 held from reset -> owners 0,1,2,3,0 in turn; each tenure is 4 cycles followed by a 1-cycle gap; preempt pulses in each gap.
- i_w_req=1111 with i_w_lock=0010 and owner 1 -> master 1 holds for 10+ cycles with no preempt; after the lock is cleared, release happens on the next evaluated cycle.
- Owner 0 with i_w_src_active=0011 for one cycle -> conflict=1 next cycle and it stays set; i_w_clr_err pulse -> conflict=0; src_active=0001 alone -> no conflict.
- Async reset asserted mid-GRANT of master 3 -> grant=0000 immediately. After reset release with i_w_req=1001 -> master 0 is granted first (rr_ptr=0).

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter
// Grants drive rights on the shared OR-combined bus to one source at a time.
// Priority is round-robin. An unlocked owner is released once it has held the
// bus for p_max_hold cycles while another source waits. A one-cycle turnaround
// (RELEASE) always separates owners so the bus returns to all-zero. Any source
// that drives the bus without holding the grant raises a sticky conflict flag.
//
// Ports:
//   i_w_clk, i_w_rst_n : clock (rising edge), asynchronous active-low reset
//   i_w_req            : per-source level request
//   i_w_lock           : per-source lock; the owner's bit suppresses preemption
//   i_w_src_active     : per-source "driving nonzero on the bus" indication
//   i_w_clr_err        : clears o_r_conflict (a new conflict wins over clear)
//   o_r_grant          : one-hot drive enable, zero when there is no owner
//   o_r_owner          : index of the owner, zero when there is no owner
//   o_r_busy           : high while a source owns the bus
//   o_r_preempt        : one-cycle pulse in the RELEASE cycle of a forced release
//   o_r_conflict       : sticky unauthorised-driver flag
module bus_arbiter #(
    parameter int p_num_masters = 4,
    parameter int p_max_hold    = 4
) (
    input  logic                             i_w_clk,
    input  logic                             i_w_rst_n,
    input  logic [p_num_masters-1:0]         i_w_req,
    input  logic [p_num_masters-1:0]         i_w_lock,
    input  logic [p_num_masters-1:0]         i_w_src_active,
    input  logic                             i_w_clr_err,
    output logic [p_num_masters-1:0]         o_r_grant,
    output logic [$clog2(p_num_masters)-1:0] o_r_owner,
    output logic                             o_r_busy,
    output logic                             o_r_preempt,
    output logic                             o_r_conflict
);

    localparam int ow = $clog2(p_num_masters);
    localparam int hw = $clog2(p_max_hold + 1);
    localparam logic [hw-1:0] hold_max = hw'(p_max_hold);
    localparam logic [p_num_masters-1:0] one_hot_0 = {{(p_num_masters-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        st_idle,
        st_grant,
        st_release
    } state_t;

    state_t                   state_q, state_d;
    logic [ow-1:0]            rr_ptr_q, rr_ptr_d;
    logic [hw-1:0]            hold_cnt_q, hold_cnt_d;
    logic [hw-1:0]            hold_inc;
    logic [p_num_masters-1:0] grant_d;
    logic [ow-1:0]            owner_d;
    logic                     busy_d, preempt_d, conflict_d;
    logic                     found;
    logic [ow-1:0]            winner, winner_next;
    logic [ow:0]              idx;
    logic                     owner_req, owner_lock, others_req, conflict_set;

    // Round-robin search: first requesting index visiting rr_ptr, rr_ptr+1, ...
    // modulo N. The index is formed one bit wider so the wrap can be detected
    // for any N, power of two or not.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < p_num_masters; i++) begin
            idx = {1'b0, rr_ptr_q} + (ow+1)'(i);
            if (idx >= (ow+1)'(p_num_masters)) begin
                idx = idx - (ow+1)'(p_num_masters);
            end
            if (!found && i_w_req[idx[ow-1:0]]) begin
                found  = 1'b1;
                winner = idx[ow-1:0];
            end
        end
    end

    // The grant register is one-hot on the owner while in GRANT and zero
    // otherwise, so masking with it answers "owner" vs "anyone else" directly.
    // The same mask makes every active source a conflict outside GRANT.
    assign owner_req    = |(i_w_req & o_r_grant);
    assign owner_lock   = |(i_w_lock & o_r_grant);
    assign others_req   = |(i_w_req & ~o_r_grant);
    assign conflict_set = |(i_w_src_active & ~o_r_grant);
    assign winner_next  = (winner == ow'(p_num_masters - 1)) ? '0 : winner + ow'(1);
    assign hold_inc     = (hold_cnt_q < hold_max) ? hold_cnt_q + hw'(1) : hold_cnt_q;

    // Next-state and registered-output logic. All outputs are produced here
    // and registered together with the state so they change on the same edge.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        grant_d    = o_r_grant;
        owner_d    = o_r_owner;
        busy_d     = o_r_busy;
        preempt_d  = 1'b0;
        conflict_d = conflict_set ? 1'b1 : (i_w_clr_err ? 1'b0 : o_r_conflict);

        case (state_q)
            st_idle, st_release: begin
                if (found) begin
                    state_d    = st_grant;
                    grant_d    = one_hot_0 << winner;
                    owner_d    = winner;
                    busy_d     = 1'b1;
                    hold_cnt_d = hw'(1);
                    rr_ptr_d   = winner_next;
                end else begin
                    state_d    = st_idle;
                    grant_d    = '0;
                    owner_d    = '0;
                    busy_d     = 1'b0;
                    hold_cnt_d = '0;
                end
            end
            st_grant: begin
                if (!owner_req) begin
                    state_d    = st_release;
                    grant_d    = '0;
                    owner_d    = '0;
                    busy_d     = 1'b0;
                    hold_cnt_d = '0;
                end else if (owner_lock) begin
                    // Keep counting so an expired hold is enforced as soon
                    // as the lock drops.
                    hold_cnt_d = hold_inc;
                end else if ((hold_cnt_q >= hold_max) && others_req) begin
                    state_d    = st_release;
                    grant_d    = '0;
                    owner_d    = '0;
                    busy_d     = 1'b0;
                    hold_cnt_d = '0;
                    preempt_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_inc;
                end
            end
            default: begin
                state_d    = st_idle;
                grant_d    = '0;
                owner_d    = '0;
                busy_d     = 1'b0;
                hold_cnt_d = '0;
            end
        endcase
    end

    // State and output registers; reset drops the grant immediately.
    always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
        if (!i_w_rst_n) begin
            state_q      <= st_idle;
            rr_ptr_q     <= '0;
            hold_cnt_q   <= '0;
            o_r_grant    <= '0;
            o_r_owner    <= '0;
            o_r_busy     <= 1'b0;
            o_r_preempt  <= 1'b0;
            o_r_conflict <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            hold_cnt_q   <= hold_cnt_d;
            o_r_grant    <= grant_d;
            o_r_owner    <= owner_d;
            o_r_busy     <= busy_d;
            o_r_preempt  <= preempt_d;
            o_r_conflict <= conflict_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
// Self-checking bench for bus_arbiter (N=4, max hold 4). Every stimulus cycle
// pushes the expected output word, produced by a behavioural model of the
// arbiter, onto a scoreboard queue; it is popped and compared once the DUT
// has clocked. Each scenario task adds its own directed checks on top.
module tb_bus_arbiter;

    localparam int N    = 4;
    localparam int MAXH = 4;
    localparam int OW   = $clog2(N);
    localparam int OBW  = N + OW + 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  lock = '0;
    logic [N-1:0]  src_active = '0;
    logic          clr_err = 1'b0;
    logic [N-1:0]  grant;
    logic [OW-1:0] owner;
    logic          busy, preempt, conflict;

    int vectors_applied = 0;
    int miscompares = 0;
    logic [OBW-1:0] exp_q[$];

    // Behavioural model state: 0 idle, 1 grant, 2 release
    int m_state, m_owner, m_hold, m_ptr;
    bit m_preempt, m_conflict;

    bus_arbiter #(.p_num_masters(N), .p_max_hold(MAXH)) dut (
        .i_w_clk        (clk),
        .i_w_rst_n      (rst_n),
        .i_w_req        (req),
        .i_w_lock       (lock),
        .i_w_src_active (src_active),
        .i_w_clr_err    (clr_err),
        .o_r_grant      (grant),
        .o_r_owner      (owner),
        .o_r_busy       (busy),
        .o_r_preempt    (preempt),
        .o_r_conflict   (conflict)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Watchdog so the run always ends even if a scenario stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void model_reset();
        m_state    = 0;
        m_owner    = 0;
        m_hold     = 0;
        m_ptr      = 0;
        m_preempt  = 1'b0;
        m_conflict = 1'b0;
    endfunction

    function automatic logic [OBW-1:0] model_out();
        logic [N-1:0] one;
        logic [N-1:0] g;
        one = 1;
        g = (m_state == 1) ? (one << m_owner) : '0;
        return {g, OW'((m_state == 1) ? m_owner : 0), (m_state == 1), m_preempt, m_conflict};
    endfunction

    // One clock edge of the arbiter as described in its operating rules
    function automatic void model_step(input logic [N-1:0] r, input logic [N-1:0] l,
                                       input logic [N-1:0] a, input logic c);
        bit set_err;
        bit found;
        int cand;
        logic [N-1:0] one;
        one = 1;
        set_err = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (a[j] && (m_state != 1 || j != m_owner)) set_err = 1'b1;
        end
        m_conflict = set_err ? 1'b1 : (c ? 1'b0 : m_conflict);
        m_preempt = 1'b0;
        if (m_state != 1) begin
            found = 1'b0;
            for (int j = 0; j < N; j++) begin
                cand = (m_ptr + j) % N;
                if (!found && r[cand]) begin
                    found = 1'b1;
                    m_owner = cand;
                end
            end
            if (found) begin
                m_state = 1;
                m_hold  = 1;
                m_ptr   = (m_owner + 1) % N;
            end else begin
                m_state = 0;
            end
        end else if (!r[m_owner]) begin
            m_state = 2;
        end else if (l[m_owner]) begin
            if (m_hold < MAXH) m_hold++;
        end else if (m_hold >= MAXH && (r & ~(one << m_owner)) != 0) begin
            m_state   = 2;
            m_preempt = 1'b1;
        end else begin
            if (m_hold < MAXH) m_hold++;
        end
    endfunction

    function automatic logic [OBW-1:0] dut_word();
        return {grant, owner, busy, preempt, conflict};
    endfunction

    // Drive one cycle of inputs at the falling edge, queue the expected
    // result, and return 1 time unit after the following rising edge.
    task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] l,
                                 input logic [N-1:0] a, input logic c);
        @(negedge clk);
        req        = r;
        lock       = l;
        src_active = a;
        clr_err    = c;
        model_step(r, l, a, c);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst_n      = 1'b0;
        req        = '0;
        lock       = '0;
        src_active = '0;
        clr_err    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            vectors_applied++;
            if (dut_word() !== '0) begin
                miscompares++;
                $display("[TB] FAIL reset_outputs cycle %0d: got %b, expected %b", i, dut_word(), {OBW{1'b0}});
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single_request();
        logic [OBW-1:0] e;
        int held;
        held = 0;
        for (int i = 0; i < 9; i++) begin
            applyStimulus((i < 6) ? 4'b0100 : 4'b0000, 4'b0000, 4'b0000, 1'b0);
            e = exp_q.pop_front();
            vectors_applied++;
            if (dut_word() !== e) begin
                miscompares++;
                $display("[TB] FAIL single_req step %0d: got %b, expected %b", i, dut_word(), e);
            end
            if (grant == 4'b0100 && owner == 2'd2) held++;
        end
        vectors_applied++;
        if (held != 6) begin
            miscompares++;
            $display("[TB] FAIL single_req_tenure: got %0d cycles, expected 6", held);
        end
    endtask

    task automatic test_round_robin();
        logic [OBW-1:0] e;
        int starts[$];
        int exp_starts[5];
        int pulses;
        logic was_busy;
        exp_starts = '{0, 1, 2, 3, 0};
        pulses = 0;
        was_busy = 1'b0;
        applyReset();
        for (int i = 0; i < 24; i++) begin
            applyStimulus(4'b1111, 4'b0000, 4'b0000, 1'b0);
            e = exp_q.pop_front();
            vectors_applied++;
            if (dut_word() !== e) begin
                miscompares++;
                $display("[TB] FAIL round_robin step %0d: got %b, expected %b", i, dut_word(), e);
            end
            if (busy && !was_busy) starts.push_back(int'(owner));
            if (preempt) pulses++;
            was_busy = busy;
        end
        vectors_applied++;
        if (pulses != 4) begin
            miscompares++;
            $display("[TB] FAIL rr_preempt_count: got %0d, expected 4", pulses);
        end
        for (int k = 0; k < 5; k++) begin
            vectors_applied++;
            if (k >= starts.size() || starts[k] != exp_starts[k]) begin
                miscompares++;
                $display("[TB] FAIL rr_order slot %0d: got %0d, expected %0d", k,
                         (k < starts.size()) ? starts[k] : -1, exp_starts[k]);
            end
        end
    endtask

    task automatic test_lock();
        logic [OBW-1:0] e;
        bit reached;
        int bad;
        reached = 1'b0;
        bad = 0;
        applyReset();
        for (int i = 0; i < 10 && !reached; i++) begin
            applyStimulus(4'b1111, 4'b0010, 4'b0000, 1'b0);
            e = exp_q.pop_front();
            vectors_applied++;
            if (dut_word() !== e) begin
                miscompares++;
                $display("[TB] FAIL lock_acquire step %0d: got %b, expected %b", i, dut_word(), e);
            end
            if (busy && owner == 2'd1) reached = 1'b1;
        end
        vectors_applied++;
        if (!reached) begin
            miscompares++;
            $display("[TB] FAIL lock_acquire_timeout: got no owner 1, expected owner 1 within 10 cycles");
        end
        for (int i = 0; i < 12; i++) begin
            applyStimulus(4'b1111, 4'b0010, 4'b0000, 1'b0);
            e = exp_q.pop_front();
            vectors_applied++;
            if (dut_word() !== e) begin
                miscompares++;
                $display("[TB] FAIL lock_hold step %0d: got %b, expected %b", i, dut_word(), e);
            end
            if (owner != 2'd1 || !busy || preempt) bad++;
        end
        vectors_applied++;
        if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL lock_hold_owner: got %0d bad cycles, expected 0", bad);
        end
        applyStimulus(4'b1111, 4'b0000, 4'b0000, 1'b0);
        e = exp_q.pop_front();
        vectors_applied++;
        if (dut_word() !== e || grant !== 4'b0000 || preempt !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL lock_release: got %b, expected %b with preempt", dut_word(), e);
        end
    endtask

    task automatic test_conflict();
        logic [OBW-1:0] e;
        logic [N-1:0] act_tbl[7];
        logic clr_tbl[7];
        logic exp_conf[7];
        act_tbl  = '{4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0100};
        clr_tbl  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_conf = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        applyReset();
        for (int i = 0; i < 7; i++) begin
            applyStimulus(4'b0001, 4'b0000, act_tbl[i], clr_tbl[i]);
            e = exp_q.pop_front();
            vectors_applied++;
            if (dut_word() !== e || conflict !== exp_conf[i]) begin
                miscompares++;
                $display("[TB] FAIL conflict step %0d: got %b, expected %b (flag %b)", i, dut_word(), e, exp_conf[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [OBW-1:0] e;
        applyReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b1000, 4'b0000, 4'b0000, 1'b0);
            e = exp_q.pop_front();
            vectors_applied++;
            if (dut_word() !== e) begin
                miscompares++;
                $display("[TB] FAIL async_pre step %0d: got %b, expected %b", i, dut_word(), e);
            end
        end
        #2;
        rst_n = 1'b0;
        req   = '0;
        #1;
        vectors_applied++;
        if (dut_word() !== '0) begin
            miscompares++;
            $display("[TB] FAIL async_reset_drop: got %b, expected %b", dut_word(), {OBW{1'b0}});
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b1001, 4'b0000, 4'b0000, 1'b0);
        e = exp_q.pop_front();
        vectors_applied++;
        if (dut_word() !== e || grant !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL async_regrant: got %b, expected %b", dut_word(), e);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_request();
        test_round_robin();
        test_lock();
        test_conflict();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
